// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle between the two data-memory requesters (core, aux), the arbiter and the three banks.
// The slave modport is the arbiter's view; the master modport is the requester/bank environment.
interface dmem_port_arbiter_if #(
   parameter int AW = 14
);
   logic          c_req;
   logic [3:0]    c_we;
   logic [31:0]   c_addr;
   logic [31:0]   c_wd;
   logic          c_gnt;
   logic          c_stall;
   logic          c_rvalid;
   logic          a_req;
   logic [3:0]    a_we;
   logic [31:0]   a_addr;
   logic [31:0]   a_wd;
   logic          a_gnt;
   logic          a_stall;
   logic          a_rvalid;
   logic [31:0]   rdata;
   logic          dec_err;
   logic          mem0_en;
   logic          mem1_en;
   logic          mem2_en;
   logic [3:0]    mem_we;
   logic [31:0]   mem_wd;
   logic [AW-1:0] mem_wa;
   logic [31:0]   bank0_rdata;
   logic [31:0]   bank1_rdata;
   logic [31:0]   bank2_rdata;
   logic [31:0]   conflict_cnt;

   modport slave (
      input  c_req, c_we, c_addr, c_wd, a_req, a_we, a_addr, a_wd,
      input  bank0_rdata, bank1_rdata, bank2_rdata,
      output c_gnt, c_stall, c_rvalid, a_gnt, a_stall, a_rvalid, rdata, dec_err,
      output mem0_en, mem1_en, mem2_en, mem_we, mem_wd, mem_wa, conflict_cnt
   );

   modport master (
      output c_req, c_we, c_addr, c_wd, a_req, a_we, a_addr, a_wd,
      output bank0_rdata, bank1_rdata, bank2_rdata,
      input  c_gnt, c_stall, c_rvalid, a_gnt, a_stall, a_rvalid, rdata, dec_err,
      input  mem0_en, mem1_en, mem2_en, mem_we, mem_wd, mem_wa, conflict_cnt
   );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Two-master arbiter for the three data-memory banks: core-priority with an aux anti-starvation
// override, bank decode, shared strobe mux and 1-cycle read-data return to the issuing master.
module dmem_port_arbiter #(
   parameter int MAX_WAIT = 4,
   parameter int AW       = 14
) (
   input logic                i_clk,
   input logic                i_rst,
   dmem_port_arbiter_if.slave bus
);
   localparam logic [3:0] MW      = 4'(MAX_WAIT);
   localparam logic [1:0] BANK_NO = 2'd3;

   // Bank 0 is tested first so the 0x3xxx_xxxx overlap with bank 1 resolves to a single enable.
   function automatic logic [1:0] f_bank(input logic [3:0] hi);
      if (hi[3:2] == 2'b00 && hi[0]) return 2'd0;
      else if (hi[3:1] == 3'b001)    return 2'd1;
      else if (hi == 4'b1000)        return 2'd2;
      else                           return BANK_NO;
   endfunction

   logic [3:0]  r_wait_cnt;
   logic [31:0] r_conflict;
   logic        r_rd_pend;
   logic        r_rd_owner;
   logic [1:0]  r_rd_bank;

   logic        w_c_req, w_a_req, w_a_gnt, w_c_gnt, w_any;
   logic [3:0]  w_we;
   logic [31:0] w_addr, w_wd;
   logic [1:0]  w_bank;
   logic        w_dec_err;
   logic [31:0] w_rdata;
   logic        w_unused;

   // Reset masks the requests so every combinational strobe is quiet while rst is held.
   assign w_c_req = bus.c_req & ~i_rst;
   assign w_a_req = bus.a_req & ~i_rst;
   assign w_a_gnt = w_a_req & (~w_c_req | (r_wait_cnt == MW));
   assign w_c_gnt = w_c_req & ~w_a_gnt;
   assign w_any   = w_c_gnt | w_a_gnt;

   always_comb begin
      w_we   = '0;
      w_addr = '0;
      w_wd   = '0;
      if (w_a_gnt) begin
         w_we   = bus.a_we;
         w_addr = bus.a_addr;
         w_wd   = bus.a_wd;
      end else if (w_c_gnt) begin
         w_we   = bus.c_we;
         w_addr = bus.c_addr;
         w_wd   = bus.c_wd;
      end
   end

   assign w_bank    = f_bank(w_addr[31:28]);
   assign w_dec_err = w_any & (w_bank == BANK_NO);
   assign w_unused  = ^{w_addr[1:0], w_addr[27:AW+2]};

   assign bus.c_gnt        = w_c_gnt;
   assign bus.a_gnt        = w_a_gnt;
   assign bus.c_stall      = w_c_req & ~w_c_gnt;
   assign bus.a_stall      = w_a_req & ~w_a_gnt;
   assign bus.dec_err      = w_dec_err;
   assign bus.mem0_en      = w_any & (w_bank == 2'd0);
   assign bus.mem1_en      = w_any & (w_bank == 2'd1);
   assign bus.mem2_en      = w_any & (w_bank == 2'd2);
   assign bus.mem_we       = w_dec_err ? 4'h0 : w_we;
   assign bus.mem_wd       = w_wd;
   assign bus.mem_wa       = w_addr[AW+1:2];
   assign bus.conflict_cnt = r_conflict;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wait_cnt <= '0;
         r_conflict <= '0;
         r_rd_pend  <= 1'b0;
         r_rd_owner <= 1'b0;
         r_rd_bank  <= BANK_NO;
      end else begin
         if (!bus.a_req || w_a_gnt)
            r_wait_cnt <= '0;
         else if (r_wait_cnt != MW)
            r_wait_cnt <= r_wait_cnt + 4'd1;
         if (bus.c_req && bus.a_req)
            r_conflict <= r_conflict + 32'd1;
         // A decode-error read still returns (zero) data so the requester never hangs.
         r_rd_pend  <= w_any & (w_we == 4'h0);
         r_rd_owner <= w_a_gnt;
         r_rd_bank  <= w_bank;
      end
   end

   always_comb begin
      w_rdata = '0;
      if (r_rd_pend) begin
         case (r_rd_bank)
            2'd0:    w_rdata = bus.bank0_rdata;
            2'd1:    w_rdata = bus.bank1_rdata;
            2'd2:    w_rdata = bus.bank2_rdata;
            default: w_rdata = '0;
         endcase
      end
   end

   assign bus.rdata    = w_rdata;
   assign bus.c_rvalid = r_rd_pend & ~r_rd_owner;
   assign bus.a_rvalid = r_rd_pend &  r_rd_owner;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed and small randomized checks of dmem_port_arbiter against three modeled sync banks.
module tb_dmem_port_arbiter;
   localparam int MAX_WAIT = 4;
   localparam int AW       = 14;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   dmem_port_arbiter_if #(.AW(AW)) bus ();

   dmem_port_arbiter #(.MAX_WAIT(MAX_WAIT), .AW(AW)) dut (
      .i_clk(clk),
      .i_rst(rst),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous bank models, cleared by reset, 1-cycle read latency.
   logic [31:0] bmem [3][256];
   logic [31:0] brd  [3];
   logic [2:0]  ben;
   assign ben = {bus.mem2_en, bus.mem1_en, bus.mem0_en};
   assign bus.bank0_rdata = brd[0];
   assign bus.bank1_rdata = brd[1];
   assign bus.bank2_rdata = brd[2];

   always @(posedge clk) begin
      if (rst) begin
         for (int b = 0; b < 3; b++) begin
            brd[b] <= '0;
            for (int i = 0; i < 256; i++) bmem[b][i] <= '0;
         end
      end else begin
         for (int b = 0; b < 3; b++) begin
            if (ben[b]) begin
               brd[b] <= bmem[b][bus.mem_wa[7:0]];
               for (int j = 0; j < 4; j++)
                  if (bus.mem_we[j]) bmem[b][bus.mem_wa[7:0]][8*j +: 8] <= bus.mem_wd[8*j +: 8];
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic creq(input logic [3:0] we, input logic [31:0] a, input logic [31:0] d);
      bus.c_req = 1'b1; bus.c_we = we; bus.c_addr = a; bus.c_wd = d;
   endtask
   task automatic areq(input logic [3:0] we, input logic [31:0] a, input logic [31:0] d);
      bus.a_req = 1'b1; bus.a_we = we; bus.a_addr = a; bus.a_wd = d;
   endtask
   task automatic cidle(); bus.c_req = 1'b0; bus.c_we = '0; bus.c_addr = '0; bus.c_wd = '0; endtask
   task automatic aidle(); bus.a_req = 1'b0; bus.a_we = '0; bus.a_addr = '0; bus.a_wd = '0; endtask

   function automatic logic [31:0] base_of(input int b);
      case (b)
         0:       return 32'h1000_0000;
         1:       return 32'h2000_0000;
         default: return 32'h8000_0000;
      endcase
   endfunction

   logic [31:0] rmem [3][8];
   logic        pc, pa, exp_cv, exp_av;
   logic [3:0]  cwe, awe;
   logic [31:0] cad, cwd, aad, awd, exp_d;
   int          cb, ci, ab, ai, a_stalls;

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      aidle();
      creq(4'h0, 32'h1000_0000, 32'h0);
      @(posedge clk); @(negedge clk);
      // Reset state: request present but masked.
      chk("rst_c_gnt", bus.c_gnt, 0);
      chk("rst_c_stall", bus.c_stall, 0);
      chk("rst_en", ben, 0);
      chk("rst_we", bus.mem_we, 0);
      chk("rst_rvalid", {bus.c_rvalid, bus.a_rvalid}, 0);
      chk("rst_rdata", bus.rdata, 0);
      chk("rst_conflict", bus.conflict_cnt, 0);
      step();
      rst = 1'b0;
      cidle();

      // Core store then load, bank 0 word 1.
      step(); creq(4'hF, 32'h1000_0004, 32'hDEAD_BEEF);
      @(negedge clk);
      chk("sw_gnt", bus.c_gnt, 1);
      chk("sw_en", ben, 3'b001);
      chk("sw_wa", 32'(bus.mem_wa), 1);
      chk("sw_we", bus.mem_we, 4'hF);
      chk("sw_wd", bus.mem_wd, 32'hDEAD_BEEF);
      chk("sw_decerr", bus.dec_err, 0);
      step(); creq(4'h0, 32'h1000_0004, 32'h0);
      @(negedge clk);
      chk("lw_gnt", bus.c_gnt, 1);
      chk("lw_we", bus.mem_we, 0);
      chk("sw_no_rvalid", bus.c_rvalid, 0);
      step(); cidle();
      @(negedge clk);
      chk("lw_rvalid", bus.c_rvalid, 1);
      chk("lw_a_rvalid", bus.a_rvalid, 0);
      chk("lw_rdata", bus.rdata, 32'hDEAD_BEEF);

      // Partial store to bank 1 word 2, read back merged word.
      step(); creq(4'b0011, 32'h2000_0008, 32'h1234_5678);
      @(negedge clk);
      chk("b1_en", ben, 3'b010);
      chk("b1_wa", 32'(bus.mem_wa), 2);
      chk("b1_we", bus.mem_we, 4'b0011);
      step(); creq(4'h0, 32'h2000_0008, 32'h0);
      step(); cidle();
      @(negedge clk);
      chk("b1_rdata", bus.rdata, 32'h0000_5678);

      // Read routing: aux read of bank 2, then core read of bank 0 back-to-back.
      step(); areq(4'hF, 32'h8000_0000, 32'hA5A5_0001);
      @(negedge clk);
      chk("a_sw_gnt", bus.a_gnt, 1);
      chk("a_sw_en", ben, 3'b100);
      step(); aidle(); creq(4'hF, 32'h1000_0000, 32'hC0C0_0002);
      step(); cidle(); areq(4'h0, 32'h8000_0000, 32'h0);
      @(negedge clk);
      chk("a_lw_gnt", bus.a_gnt, 1);
      step(); aidle(); creq(4'h0, 32'h1000_0000, 32'h0);
      @(negedge clk);
      chk("rt_c_gnt", bus.c_gnt, 1);
      chk("rt_rvalids1", {bus.c_rvalid, bus.a_rvalid}, 2'b01);
      chk("rt_rdata1", bus.rdata, 32'hA5A5_0001);
      step(); cidle();
      @(negedge clk);
      chk("rt_rvalids2", {bus.c_rvalid, bus.a_rvalid}, 2'b10);
      chk("rt_rdata2", bus.rdata, 32'hC0C0_0002);

      // Starvation: both held; core four times, aux on the fifth.
      step(); creq(4'h0, 32'h1000_0004, 32'h0); areq(4'h0, 32'h8000_0000, 32'h0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk($sformatf("starve_c_gnt%0d", k), bus.c_gnt, (k < 4) ? 1 : 0);
         chk($sformatf("starve_a_gnt%0d", k), bus.a_gnt, (k == 4) ? 1 : 0);
         if (k > 0) chk($sformatf("starve_c_rvalid%0d", k), bus.c_rvalid, 1);
         if (k < 4) step();
      end
      chk("starve_c_stall", bus.c_stall, 1);
      step(); cidle(); aidle();
      @(negedge clk);
      chk("starve_conflict", bus.conflict_cnt, 5);
      chk("starve_a_rvalid", bus.a_rvalid, 1);
      chk("starve_rdata", bus.rdata, 32'hA5A5_0001);
      step(); creq(4'h0, 32'h1000_0004, 32'h0); areq(4'h0, 32'h8000_0000, 32'h0);
      @(negedge clk);
      chk("wait_cleared", bus.c_gnt, 1);
      step(); cidle(); aidle();

      // Core write and aux read of the same word: aux sees the new data.
      step(); creq(4'hF, 32'h8000_0010, 32'h55AA_55AA); areq(4'h0, 32'h8000_0010, 32'h0);
      @(negedge clk);
      chk("same_c_gnt", bus.c_gnt, 1);
      chk("same_a_stall", bus.a_stall, 1);
      step(); cidle();
      @(negedge clk);
      chk("same_a_gnt", bus.a_gnt, 1);
      step(); aidle();
      @(negedge clk);
      chk("same_a_rvalid", bus.a_rvalid, 1);
      chk("same_rdata", bus.rdata, 32'h55AA_55AA);

      // Decode error: read returns zero, write is suppressed.
      step(); creq(4'h0, 32'h4000_0000, 32'h0);
      @(negedge clk);
      chk("de_flag", bus.dec_err, 1);
      chk("de_gnt", bus.c_gnt, 1);
      chk("de_en", ben, 0);
      chk("de_we", bus.mem_we, 0);
      step(); creq(4'hF, 32'h0000_0000, 32'hFFFF_FFFF);
      @(negedge clk);
      chk("de_rvalid", bus.c_rvalid, 1);
      chk("de_rdata", bus.rdata, 0);
      chk("de_w_we", bus.mem_we, 0);
      chk("de_w_en", ben, 0);
      step(); cidle();
      @(negedge clk);
      chk("de_w_no_rvalid", bus.c_rvalid, 0);

      // Reset raised with a read in flight.
      step(); creq(4'h0, 32'h1000_0004, 32'h0);
      @(negedge clk);
      chk("mr_gnt", bus.c_gnt, 1);
      rst = 1'b1;
      #1;
      chk("mr_c_gnt", bus.c_gnt, 0);
      chk("mr_c_stall", bus.c_stall, 0);
      chk("mr_en", ben, 0);
      chk("mr_rvalid", {bus.c_rvalid, bus.a_rvalid}, 0);
      chk("mr_conflict", bus.conflict_cnt, 0);
      step(); rst = 1'b0; cidle();
      @(negedge clk);
      chk("mr_post_rvalid", {bus.c_rvalid, bus.a_rvalid}, 0);
      chk("mr_post_rdata", bus.rdata, 0);

      // Random two-master traffic against a reference memory (banks were cleared by reset).
      for (int b = 0; b < 3; b++) for (int i = 0; i < 8; i++) rmem[b][i] = '0;
      pc = 0; pa = 0; exp_cv = 0; exp_av = 0; exp_d = '0; a_stalls = 0;
      cb = 0; ci = 0; ab = 0; ai = 0; cwe = '0; awe = '0; cad = '0; aad = '0; cwd = '0; awd = '0;
      for (int n = 0; n < 80; n++) begin
         step();
         if (!pc && $urandom_range(0, 2) != 0) begin
            pc = 1; cb = $urandom_range(0, 2); ci = $urandom_range(0, 7);
            cwe = ($urandom_range(0, 1) != 0) ? 4'hF : 4'h0;
            cad = base_of(cb) | 32'(ci << 2); cwd = $urandom;
         end
         if (!pa && $urandom_range(0, 2) != 0) begin
            pa = 1; ab = $urandom_range(0, 2); ai = $urandom_range(0, 7);
            awe = ($urandom_range(0, 1) != 0) ? 4'hF : 4'h0;
            aad = base_of(ab) | 32'(ai << 2); awd = $urandom;
         end
         if (pc) creq(cwe, cad, cwd); else cidle();
         if (pa) areq(awe, aad, awd); else aidle();
         @(negedge clk);
         chk("rnd_c_rvalid", bus.c_rvalid, exp_cv);
         chk("rnd_a_rvalid", bus.a_rvalid, exp_av);
         chk("rnd_rdata", bus.rdata, (exp_cv | exp_av) ? exp_d : 32'h0);
         exp_cv = 0; exp_av = 0;
         if (bus.c_gnt && pc) begin
            if (cwe == 4'h0) begin exp_cv = 1; exp_d = rmem[cb][ci]; end
            else rmem[cb][ci] = cwd;
            pc = 0;
         end else if (bus.a_gnt && pa) begin
            if (awe == 4'h0) begin exp_av = 1; exp_d = rmem[ab][ai]; end
            else rmem[ab][ai] = awd;
            pa = 0;
         end
         if (bus.a_stall) a_stalls++;
         else a_stalls = 0;
         chk("rnd_aux_wait", (a_stalls <= MAX_WAIT) ? 1 : 0, 1);
      end
      step(); cidle(); aidle();
      @(negedge clk);
      chk("rnd_last_rvalid", {bus.c_rvalid, bus.a_rvalid}, {exp_cv, exp_av});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
